// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC,
//   talks to a variable-latency req/ack instruction memory, presents
//   {PC+4, instruction} to IF/ID with a write strobe, honours the hazard-unit
//   stall and performs branch/jump redirects with an IF/ID flush.
//
// Parameters
//   RESET_PC         PC loaded on reset (word aligned)
//
// Ports
//   clk              in   1   rising-edge clock
//   rst_n            in   1   asynchronous active-low reset
//   imem_req         out  1   instruction-memory request
//   imem_addr        out  32  request address (= PC)
//   imem_ack         in   1   one-cycle response strobe
//   imem_rdata       in   32  instruction word, valid with imem_ack
//   stall            in   1   IF/ID must hold this cycle
//   redirect_valid   in   1   branch/jump taken (single-cycle pulse)
//   redirect_target  in   32  new PC, word aligned
//   PCAddResult      out  32  PC+4 of the presented instruction
//   Instruction      out  32  presented instruction word
//   IFIDWrite        out  1   IF/ID accepts this edge
//   IFIDFlush        out  1   IF/ID clears this edge
//   perf_fetched     out  32  (FETCH_PERF_CNT_EN only) saturating count of IFIDWrite
//   perf_bubbles     out  32  (FETCH_PERF_CNT_EN only) saturating count of cycles without IFIDWrite
//
// Configuration macro
//   FETCH_PERF_CNT_EN  adds the two performance counters and their ports.
// -----------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] PCAddResult,
  output logic [31:0] Instruction,
  output logic        IFIDWrite,
  output logic        IFIDFlush
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,  // request outstanding
    ST_HOLD = 2'd1,  // word captured while IF/ID stalled
    ST_DROP = 2'd2   // redirected, waiting out the stale ack
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_buf;
  logic [31:0] w_buf_nxt;
  logic        r_run;
  logic [31:0] w_pc_inc;
  logic        w_req;
  logic        w_write;
  logic        w_flush;
  logic [31:0] w_instr;

  assign w_pc_inc = r_pc + 32'd4;

  // r_run is cleared by reset and set on the first edge after release, so all
  // outputs read 0 during reset and the first request appears one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // State, PC and hold-buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_REQ;
      r_pc    <= RESET_PC;
      r_buf   <= 32'h0000_0000;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_buf   <= w_buf_nxt;
    end
  end

  // Next-state and IF/ID control. Redirect outranks everything, including stall.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_buf_nxt   = r_buf;
    w_req       = 1'b0;
    w_write     = 1'b0;
    w_flush     = 1'b0;
    w_instr     = imem_rdata;

    if (r_run) begin
      w_req   = (r_state == ST_REQ);
      w_instr = (r_state == ST_HOLD) ? r_buf : imem_rdata;

      if (redirect_valid) begin
        w_flush   = 1'b1;
        w_pc_nxt  = redirect_target;
        w_buf_nxt = 32'h0000_0000;
        case (r_state)
          // An un-acked request is still in flight; its ack must be swallowed.
          ST_REQ:  w_state_nxt = imem_ack ? ST_REQ : ST_DROP;
          ST_HOLD: w_state_nxt = ST_REQ;
          ST_DROP: w_state_nxt = imem_ack ? ST_REQ : ST_DROP;
          default: w_state_nxt = ST_REQ;
        endcase
      end else begin
        case (r_state)
          ST_REQ: begin
            if (imem_ack) begin
              if (stall) begin
                w_buf_nxt   = imem_rdata;
                w_state_nxt = ST_HOLD;
              end else begin
                w_write  = 1'b1;
                w_pc_nxt = w_pc_inc;
              end
            end else begin
              w_state_nxt = ST_REQ;
            end
          end
          ST_HOLD: begin
            if (!stall) begin
              w_write     = 1'b1;
              w_pc_nxt    = w_pc_inc;
              w_state_nxt = ST_REQ;
            end else begin
              w_state_nxt = ST_HOLD;
            end
          end
          ST_DROP: begin
            if (imem_ack) begin
              w_state_nxt = ST_REQ;
            end else begin
              w_state_nxt = ST_DROP;
            end
          end
          default: w_state_nxt = ST_REQ;
        endcase
      end
    end else begin
      w_state_nxt = ST_REQ;
    end
  end

  // The ack-to-IFIDWrite path is combinational so the memory word reaches
  // IF/ID in the same cycle it returns.
  assign imem_req    = w_req;
  assign imem_addr   = r_run ? r_pc : 32'h0000_0000;
  assign PCAddResult = r_run ? w_pc_inc : 32'h0000_0000;
  assign Instruction = r_run ? w_instr : 32'h0000_0000;
  assign IFIDWrite   = w_write;
  assign IFIDFlush   = w_flush;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_bubbles;

  // Saturating fetch / bubble counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= 32'h0000_0000;
      r_perf_bubbles <= 32'h0000_0000;
    end else begin
      if (w_write) begin
        if (r_perf_fetched != 32'hFFFF_FFFF) begin
          r_perf_fetched <= r_perf_fetched + 32'd1;
        end else begin
          r_perf_fetched <= r_perf_fetched;
        end
      end else begin
        if (r_perf_bubbles != 32'hFFFF_FFFF) begin
          r_perf_bubbles <= r_perf_bubbles + 32'd1;
        end else begin
          r_perf_bubbles <= r_perf_bubbles;
        end
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_bubbles = r_perf_bubbles;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
//   Self-checking bench for if_fetch_stage. A small instruction-memory model
//   answers requests with 1..3 cycle latency; a reference model tracks the PC,
//   at most one held word and whether a stale ack is still owed, and predicts
//   every IF/ID output cycle by cycle. Directed scenarios are followed by a
//   randomized run with a reset in the middle.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] PCAddResult;
  logic [31:0] Instruction;
  logic        IFIDWrite;
  logic        IFIDFlush;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .PCAddResult     (PCAddResult),
    .Instruction     (Instruction),
    .IFIDWrite       (IFIDWrite),
    .IFIDFlush       (IFIDFlush)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_bubbles    (perf_bubbles)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: PC, pending held word(s), stale-ack owed flag, counters.
  bit           m_run;
  logic [31:0]  m_pc;
  logic [31:0]  m_held[$];
  bit           m_drop;
  int unsigned  m_fetched;
  int unsigned  m_bubbles;
  int           n_writes;

  // Memory model.
  bit           mem_busy;
  int           mem_cnt;
  logic [31:0]  mem_addr;
  int           fixed_lat;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0004) return 32'h2002_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    #1;
    check_val("rst_imem_req", 32'(imem_req), 32'd0);
    check_val("rst_imem_addr", imem_addr, 32'd0);
    check_val("rst_pcadd", PCAddResult, 32'd0);
    check_val("rst_instr", Instruction, 32'd0);
    check_val("rst_ifidwrite", 32'(IFIDWrite), 32'd0);
    check_val("rst_ifidflush", 32'(IFIDFlush), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check_val("rst_perf_fetched", perf_fetched, 32'd0);
    check_val("rst_perf_bubbles", perf_bubbles, 32'd0);
`endif
    mem_busy = 1'b0;
    m_run = 1'b0;
    m_pc = RESET_PC;
    m_held.delete();
    m_drop = 1'b0;
    m_fetched = 0;
    m_bubbles = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    m_bubbles = 1;  // the edge after release sees no write
    m_run = 1'b1;
    #1;
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, advance models.
  task automatic step(input bit st, input bit rd, input logic [31:0] tgt);
    bit          e_held, e_req, e_avail, e_write, s_req;
    logic [31:0] e_word, s_addr;
    imem_ack = mem_busy && (mem_cnt == 1);
    imem_rdata = imem_ack ? mem_word(mem_addr) : $urandom();
    stall = st;
    redirect_valid = rd;
    redirect_target = tgt;
    @(negedge clk);
    e_held  = (m_held.size() != 0);
    e_req   = m_run && !e_held && !m_drop;
    e_avail = m_run && (e_held || (e_req && imem_ack));
    e_word  = e_held ? m_held[0] : imem_rdata;
    e_write = e_avail && !st && !rd;
    check_val("imem_req", 32'(imem_req), 32'(e_req));
    if (e_req) check_val("imem_addr", imem_addr, m_pc);
    check_val("IFIDWrite", 32'(IFIDWrite), 32'(e_write));
    check_val("IFIDFlush", 32'(IFIDFlush), 32'(m_run && rd));
    if (e_avail) begin
      check_val("Instruction", Instruction, e_word);
      check_val("PCAddResult", PCAddResult, m_pc + 32'd4);
    end
`ifdef FETCH_PERF_CNT_EN
    check_val("perf_fetched", perf_fetched, m_fetched);
    check_val("perf_bubbles", perf_bubbles, m_bubbles);
`endif
    if (IFIDWrite) n_writes++;
    s_req = imem_req;
    s_addr = imem_addr;

    if (e_write) m_fetched++;
    else m_bubbles++;
    if (m_run) begin
      if (rd) begin
        m_drop = (e_req || m_drop) && !imem_ack;
        m_held.delete();
        m_pc = tgt;
      end else if (m_drop) begin
        if (imem_ack) m_drop = 1'b0;
      end else if (e_held) begin
        if (!st) begin
          m_held.delete();
          m_pc = m_pc + 32'd4;
        end
      end else if (imem_ack) begin
        if (st) m_held.push_back(imem_rdata);
        else m_pc = m_pc + 32'd4;
      end
    end

    @(posedge clk);
    if (mem_busy) begin
      if (mem_cnt == 1) mem_busy = 1'b0;
      else mem_cnt--;
    end else if (s_req) begin
      mem_busy = 1'b1;
      mem_addr = s_addr;
      mem_cnt = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3));
    end
    #1;
  endtask

  initial begin
    bit          prev_rd;
    bit          rd;
    bit          st;
    logic [31:0] tgt;

    rst_n = 1'b1;
    fixed_lat = 1;
    #2;

    // 1: one-cycle memory, a write every second cycle.
    apply_reset();
    n_writes = 0;
    repeat (6) step(1'b0, 1'b0, 32'h0);
    check_val("t1_write_count", 32'(n_writes), 32'd3);

    // 2: stall on the ack of the word at PC 4 for three cycles.
    apply_reset();
    repeat (3) step(1'b0, 1'b0, 32'h0);
    n_writes = 0;
    repeat (3) step(1'b1, 1'b0, 32'h0);
    check_val("t2_stalled_writes", 32'(n_writes), 32'd0);
    step(1'b0, 1'b0, 32'h0);
    check_val("t2_release_write", 32'(n_writes), 32'd1);
    repeat (3) step(1'b0, 1'b0, 32'h0);

    // 3: three-cycle memory, redirect one cycle after the request at 0x8.
    fixed_lat = 3;
    apply_reset();
    repeat (9) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0040);
    repeat (10) step(1'b0, 1'b0, 32'h0);

    // 4: redirect in the same cycle as an ack.
    fixed_lat = 1;
    apply_reset();
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_0100);
    repeat (6) step(1'b0, 1'b0, 32'h0);

    // 5: redirect with stall while holding a word.
    apply_reset();
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0000_0200);
    repeat (6) step(1'b0, 1'b0, 32'h0);

    // PC+4 wraps at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    repeat (6) step(1'b0, 1'b0, 32'h0);

    // 6 + random: random latency/stall/redirect with a reset mid-run.
    fixed_lat = 0;
    prev_rd = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        apply_reset();
        prev_rd = 1'b0;
      end
      st = ($urandom_range(0, 99) < 25);
      rd = !prev_rd && ($urandom_range(0, 99) < 8);
      tgt = $urandom();
      tgt[1:0] = 2'b00;
      step(st, rd, tgt);
      prev_rd = rd;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
